// File: rtl/mlx90640_subpage_merge_if.sv
// Read/write bus between the subpage merge engine and its memories.
// The engine is the master: it drives the shared ROM/RAM read address and the frame-buffer write port.
interface mlx90640_subpage_merge_if #(
    parameter int DEPTH = 832,
    parameter int DATAW = 16
);
    localparam int ADDRW = $clog2(DEPTH);

    // The ROM and RAM reads are synchronous: mask/src_data answer the rd_addr of the previous cycle.
    // The frame-buffer port has no back-pressure: a word is written on every cycle that fb_we is high.
    logic [ADDRW-1:0] rd_addr;
    logic             mask_pg0;
    logic             mask_pg1;
    logic [DATAW-1:0] src_data;
    logic             fb_we;
    logic [ADDRW-1:0] fb_addr;
    logic [DATAW-1:0] fb_data;

    modport master (
        output rd_addr, fb_we, fb_addr, fb_data,
        input  mask_pg0, mask_pg1, src_data
    );

    modport slave (
        input  rd_addr, fb_we, fb_addr, fb_data,
        output mask_pg0, mask_pg1, src_data
    );
endinterface

// File: rtl/mlx90640_subpage_merge.sv
// Sweeps one captured subpage image and copies the words selected by that subpage's pattern mask
// into the frame buffer. It also tracks which subpages are fresh so it can flag a complete frame.
module mlx90640_subpage_merge #(
    parameter int DEPTH = 832,
    parameter int DATAW = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      subpage,
    mlx90640_subpage_merge_if.master  bus,
    output logic                      busy,
    output logic                      done,
    output logic                      frame_complete,
    output logic [$clog2(DEPTH):0]    wr_count,
    output logic [1:0]                dbg_state
);
    localparam int ADDRW = $clog2(DEPTH);
    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_e;

    state_e           state_q, state_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic             sp_sel_q, sp_sel_d;
    logic             drain_q, drain_d;
    logic [1:0]       seen_q, seen_d;
    logic [ADDRW:0]   tally_q, tally_d;
    logic [ADDRW:0]   wr_count_q, wr_count_d;
    logic [1:0]       seen_set;

    logic             v1_q;
    logic [ADDRW-1:0] a1_q;
    logic             fb_we_q;
    logic [ADDRW-1:0] fb_addr_q;
    logic [DATAW-1:0] fb_data_q;

    assign seen_set = seen_q | (sp_sel_q ? 2'b10 : 2'b01);

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        sp_sel_d       = sp_sel_q;
        drain_d        = drain_q;
        seen_d         = seen_q;
        wr_count_d     = wr_count_q;
        tally_d        = tally_q + {{ADDRW{1'b0}}, fb_we_q};
        done           = 1'b0;
        frame_complete = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sp_sel_d = subpage;
                    addr_d   = '0;
                    tally_d  = '0;
                    drain_d  = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // The last address is held rather than wrapped so rd_addr stays stable afterwards.
                if (addr_q == LAST_ADDR) begin
                    drain_d = 1'b0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = FINISH;
            end
            FINISH: begin
                done       = 1'b1;
                wr_count_d = tally_q;
                if (&seen_set) begin
                    frame_complete = 1'b1;
                    seen_d         = 2'b00;
                end else begin
                    seen_d = seen_set;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            sp_sel_q   <= 1'b0;
            drain_q    <= 1'b0;
            seen_q     <= 2'b00;
            tally_q    <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            sp_sel_q   <= sp_sel_d;
            drain_q    <= drain_d;
            seen_q     <= seen_d;
            tally_q    <= tally_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Stage 1 tracks the address in flight; stage 2 lines it up with the synchronous memory data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            a1_q      <= '0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else begin
            v1_q      <= (state_q == RUN);
            a1_q      <= addr_q;
            fb_we_q   <= v1_q & (sp_sel_q ? bus.mask_pg1 : bus.mask_pg0);
            fb_addr_q <= a1_q;
            fb_data_q <= bus.src_data;
        end
    end

    assign bus.rd_addr = addr_q;
    assign bus.fb_we   = fb_we_q;
    assign bus.fb_addr = fb_addr_q;
    assign bus.fb_data = fb_data_q;
    assign busy        = (state_q != IDLE);
    assign wr_count    = wr_count_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_mlx90640_subpage_merge.sv
// Bench for the subpage merge engine: chess-pattern ROM and source RAM models, write scoreboard,
// and a sweep-level model of done timing, wr_count and frame_complete.
module tb_mlx90640_subpage_merge;
    localparam int DEPTH = 832;
    localparam int DATAW = 16;
    localparam int ADDRW = $clog2(DEPTH);
    localparam int W     = ADDRW + DATAW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             subpage = 1'b0;
    logic             busy;
    logic             done;
    logic             frame_complete;
    logic [ADDRW:0]   wr_count;
    logic [1:0]       dbg_state;
    logic [DATAW-1:0] seed = '0;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    logic [1:0] seen_m = 2'b00;
    logic       wrote[DEPTH];
    int         wr_seen = 0;
    int         wr_low = 0;
    int         done_pulses = 0;

    mlx90640_subpage_merge_if #(.DEPTH(DEPTH), .DATAW(DATAW)) bus ();

    mlx90640_subpage_merge #(.DEPTH(DEPTH), .DATAW(DATAW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .subpage        (subpage),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .frame_complete (frame_complete),
        .wr_count       (wr_count),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Chess pattern over the 32-wide pixel array; aux words belong to both subpages.
    function automatic logic pg_mask(input logic sp, input int a);
        if (a >= 768) return 1'b1;
        return 1'(((a / 32) + (a % 32)) % 2) == sp;
    endfunction

    // ---------------- memory models (synchronous reads) ----------------
    always @(posedge clk) begin
        bus.mask_pg0 <= pg_mask(1'b0, int'(bus.rd_addr));
        bus.mask_pg1 <= pg_mask(1'b1, int'(bus.rd_addr));
        bus.src_data <= DATAW'(bus.rd_addr) ^ seed;
    end

    // ---------------- write monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_pulses++;
            if (bus.fb_we) begin
                wr_seen++;
                if (bus.fb_addr < 768) wr_low++;
                if (int'(bus.fb_addr) < DEPTH) wrote[bus.fb_addr] = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("fb_addr", 32'(bus.fb_addr), 32'(mon_e[W-1:DATAW]));
                    check("fb_data", 32'(bus.fb_data), 32'(mon_e[DATAW-1:0]));
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge with the DUT idle. poke pulses a stray start mid-run;
    // abort_at > 0 resets the DUT at that RUN cycle instead of finishing.
    task automatic sweep(input logic sp, input bit poke, input int abort_at);
        int n;
        bit got;
        int exp_n;
        logic [ADDRW-1:0] a_v;
        logic [DATAW-1:0] d_v;
        logic exp_fc;
        exp_n = 0;
        wr_seen = 0;
        wr_low = 0;
        done_pulses = 0;
        foreach (wrote[i]) wrote[i] = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            if (pg_mask(sp, a)) begin
                a_v = ADDRW'(a);
                d_v = DATAW'(a) ^ seed;
                exp_q.push_back({a_v, d_v});
                exp_n++;
            end
        end
        start = 1'b1;
        subpage = sp;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        n = 1;
        got = 1'b0;
        while (n < 2000) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (poke && n == 100) begin
                start = 1'b1;
                subpage = ~sp;
            end
            if (poke && n == 101) start = 1'b0;
            if (abort_at > 0 && n == abort_at) begin
                #2 rst_n = 1'b0;
                exp_q.delete();
                seen_m = 2'b00;
                repeat (3) @(negedge clk);
                check("abort_outputs", 32'({busy, done, frame_complete, bus.fb_we}), 32'd0);
                check("abort_wr_count", 32'(wr_count), 32'd0);
                rst_n = 1'b1;
                repeat (2) @(negedge clk);
                return;
            end
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(got), 32'd1);
        if (got) begin
            check("done_cycle", 32'(n), 32'(DEPTH + 3));
            check("busy_at_done", 32'(busy), 32'd1);
            seen_m = seen_m | (sp ? 2'b10 : 2'b01);
            exp_fc = (seen_m == 2'b11);
            if (exp_fc) seen_m = 2'b00;
            check("frame_complete", 32'(frame_complete), 32'(exp_fc));
        end
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
        check("fc_width", 32'(frame_complete), 32'd0);
        check("busy_clear", 32'(busy), 32'd0);
        check("wr_count", 32'(wr_count), 32'(exp_n));
        check("write_total", 32'(wr_seen), 32'(exp_n));
        check("writes_low", 32'(wr_low), 32'd384);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (5) @(negedge clk);
        check("done_pulses", 32'(done_pulses), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({busy, done, frame_complete, bus.fb_we}), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs", 32'({busy, done, frame_complete, bus.fb_we}), 32'd0);
        end
        check("idle_rd_addr", 32'(bus.rd_addr), 32'd0);
        check("idle_fb_addr", 32'(bus.fb_addr), 32'd0);
        check("idle_fb_data", 32'(bus.fb_data), 32'd0);
        check("idle_wr_count", 32'(wr_count), 32'd0);

        // subpage 0 with data equal to address
        seed = '0;
        sweep(1'b0, 1'b0, 0);
        check("sp0_wrote_0", 32'(wrote[0]), 32'd1);
        check("sp0_wrote_33", 32'(wrote[33]), 32'd1);
        check("sp0_wrote_1", 32'(wrote[1]), 32'd0);
        check("sp0_wrote_32", 32'(wrote[32]), 32'd0);

        // subpage 1 completes the frame
        sweep(1'b1, 1'b0, 0);
        check("sp1_wrote_1", 32'(wrote[1]), 32'd1);
        check("sp1_wrote_32", 32'(wrote[32]), 32'd1);
        check("sp1_wrote_0", 32'(wrote[0]), 32'd0);
        check("sp1_wrote_33", 32'(wrote[33]), 32'd0);

        // subpage 0 repeated, then subpage 1
        seed = DATAW'($urandom_range(0, 65535));
        sweep(1'b0, 1'b0, 0);
        seed = DATAW'($urandom_range(0, 65535));
        sweep(1'b0, 1'b0, 0);
        sweep(1'b1, 1'b0, 0);

        // stray start with subpage 1 during a subpage 0 run
        seed = DATAW'($urandom_range(0, 65535));
        sweep(1'b0, 1'b1, 0);

        // reset mid-run clears freshness
        sweep(1'b0, 1'b0, 400);
        seed = DATAW'($urandom_range(0, 65535));
        sweep(1'b1, 1'b0, 0);
        sweep(1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
